// File: rtl/rv64_regfile_sb_pkg.sv
// Shared configuration for the rv64 register file with scoreboard:
// default geometry and port counts used by the top and its read slices.
package rv64_regfile_sb_pkg;

    localparam int XLEN_DEF          = 64;
    localparam int REG_NUM_DEF       = 32;
    localparam int REG_ADDRWIDTH_DEF = 5;
    localparam int NREAD_DEF         = 2;
    localparam int NWRITE_DEF        = 2;

    typedef logic [XLEN_DEF-1:0]          xword_t;
    typedef logic [REG_ADDRWIDTH_DEF-1:0] reg_idx_t;

endpackage : rv64_regfile_sb_pkg

// File: rtl/rv64_regfile_sb_rf_read_bypass.sv
// One read port slice: selects the stored value or a same-cycle write,
// forces x0 to zero, and reports whether the operand is still pending.
module rf_read_bypass
    import rv64_regfile_sb_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int AW     = REG_ADDRWIDTH_DEF,
    parameter int NWRITE = NWRITE_DEF
) (
    input  logic [AW-1:0]          idx,
    input  logic [XLEN-1:0]        rf_val,
    input  logic                   busy_bit,
    input  logic [NWRITE-1:0]      wr_en,
    input  logic [NWRITE*AW-1:0]   wr_idx,
    input  logic [NWRITE*XLEN-1:0] wr_data,
    output logic [XLEN-1:0]        data,
    output logic                   busy
);

    logic            hit_s;
    logic [XLEN-1:0] byp_s;

    // Later write ports overwrite earlier matches, so the highest port wins.
    always_comb begin
        hit_s = 1'b0;
        byp_s = rf_val;
        for (int w = 0; w < NWRITE; w++) begin
            if (wr_en[w] && (wr_idx[w*AW +: AW] == idx)) begin
                hit_s = 1'b1;
                byp_s = wr_data[w*XLEN +: XLEN];
            end else begin
                hit_s = hit_s;
            end
        end
        if (idx == {AW{1'b0}}) begin
            data = {XLEN{1'b0}};
            busy = 1'b0;
        end else begin
            data = byp_s;
            busy = busy_bit & ~hit_s;
        end
    end

endmodule : rf_read_bypass

// File: rtl/rv64_regfile_sb.sv
// Integer register file with NREAD combinational read ports, NWRITE
// synchronous write ports, write-to-read bypass and a busy-bit scoreboard.
module rv64_regfile_sb
    import rv64_regfile_sb_pkg::*;
#(
    parameter int XLEN          = XLEN_DEF,
    parameter int REG_NUM       = REG_NUM_DEF,
    parameter int REG_ADDRWIDTH = REG_ADDRWIDTH_DEF,
    parameter int NREAD         = NREAD_DEF,
    parameter int NWRITE        = NWRITE_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NREAD*REG_ADDRWIDTH-1:0]  rd_idx,
    output logic [NREAD*XLEN-1:0]           rd_data,
    output logic [NREAD-1:0]                rd_busy,
    input  logic [NWRITE-1:0]               wr_en,
    input  logic [NWRITE*REG_ADDRWIDTH-1:0] wr_idx,
    input  logic [NWRITE*XLEN-1:0]          wr_data,
    input  logic                            issue_en,
    input  logic [REG_ADDRWIDTH-1:0]        issue_idx,
    input  logic                            flush,
    output logic [REG_NUM-1:0]              busy_vec
);

    localparam int AW = REG_ADDRWIDTH;

    logic [XLEN-1:0]       rf_r [REG_NUM];
    logic [REG_NUM-1:0]    busy_r;
    logic [REG_NUM-1:0]    busy_nxt_s;
    logic [NREAD*XLEN-1:0] port_data_s;
    logic [NREAD-1:0]      port_busy_s;

    // Register array update; x0 writes are dropped, highest port applied last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                rf_r[i] <= {XLEN{1'b0}};
            end
        end else begin
            for (int w = 0; w < NWRITE; w++) begin
                if (wr_en[w] && (wr_idx[w*AW +: AW] != {AW{1'b0}})) begin
                    rf_r[wr_idx[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
                end else begin
                    rf_r[0] <= {XLEN{1'b0}};
                end
            end
        end
    end

    // Scoreboard next state: flush clears everything, else writebacks clear
    // and a new issue sets, the set winning because it is the newer producer.
    always_comb begin
        busy_nxt_s = busy_r;
        if (flush) begin
            busy_nxt_s = {REG_NUM{1'b0}};
        end else begin
            for (int w = 0; w < NWRITE; w++) begin
                busy_nxt_s[wr_idx[w*AW +: AW]] =
                    wr_en[w] ? 1'b0 : busy_nxt_s[wr_idx[w*AW +: AW]];
            end
            if (issue_en && (issue_idx != {AW{1'b0}})) begin
                busy_nxt_s[issue_idx] = 1'b1;
            end else begin
                busy_nxt_s = busy_nxt_s;
            end
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Scoreboard state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= {REG_NUM{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    assign busy_vec = busy_r;

    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        rf_read_bypass #(
            .XLEN   (XLEN),
            .AW     (AW),
            .NWRITE (NWRITE)
        ) u_rd (
            .idx      (rd_idx[p*AW +: AW]),
            .rf_val   (rf_r[rd_idx[p*AW +: AW]]),
            .busy_bit (busy_r[rd_idx[p*AW +: AW]]),
            .wr_en    (wr_en),
            .wr_idx   (wr_idx),
            .wr_data  (wr_data),
            .data     (port_data_s[p*XLEN +: XLEN]),
            .busy     (port_busy_s[p])
        );
    end

    // Hold read results at zero while reset is asserted, even if a write is
    // being presented on the bus.
    always_comb begin
        if (rst) begin
            rd_data = {(NREAD*XLEN){1'b0}};
            rd_busy = {NREAD{1'b0}};
        end else begin
            rd_data = port_data_s;
            rd_busy = port_busy_s;
        end
    end

endmodule : rv64_regfile_sb

// File: tb/tb_rv64_regfile_sb.sv
// Self-checking bench for rv64_regfile_sb: a behavioural register-file and
// scoreboard model checked every negedge, plus directed literal scenarios.
module tb_rv64_regfile_sb;

    localparam int XLEN = 64;
    localparam int RN   = 32;
    localparam int AW   = 5;
    localparam int NR   = 2;
    localparam int NW   = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NR*AW-1:0]     rd_idx;
    logic [NR*XLEN-1:0]   rd_data;
    logic [NR-1:0]        rd_busy;
    logic [NW-1:0]        wr_en;
    logic [NW*AW-1:0]     wr_idx;
    logic [NW*XLEN-1:0]   wr_data;
    logic                 issue_en;
    logic [AW-1:0]        issue_idx;
    logic                 flush;
    logic [RN-1:0]        busy_vec;

    logic [XLEN-1:0] m_rf [RN];
    logic [RN-1:0]   m_busy;

    int tests = 0;
    int fails = 0;

    rv64_regfile_sb #(
        .XLEN(XLEN), .REG_NUM(RN), .REG_ADDRWIDTH(AW), .NREAD(NR), .NWRITE(NW)
    ) dut (
        .clk(clk), .rst(rst), .rd_idx(rd_idx), .rd_data(rd_data),
        .rd_busy(rd_busy), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .issue_en(issue_en), .issue_idx(issue_idx), .flush(flush),
        .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Expected read value: scan write ports from highest down, first match wins.
    function automatic logic [XLEN-1:0] exp_data(input int p);
        logic [AW-1:0] idx;
        idx = rd_idx[p*AW +: AW];
        if (rst || idx == 0) return '0;
        for (int w = NW - 1; w >= 0; w--)
            if (wr_en[w] && wr_idx[w*AW +: AW] == idx) return wr_data[w*XLEN +: XLEN];
        return m_rf[idx];
    endfunction

    function automatic logic exp_busy(input int p);
        logic [AW-1:0] idx;
        idx = rd_idx[p*AW +: AW];
        if (rst || idx == 0) return 1'b0;
        for (int w = 0; w < NW; w++)
            if (wr_en[w] && wr_idx[w*AW +: AW] == idx) return 1'b0;
        return m_busy[idx];
    endfunction

    // Compare process: every negedge, all outputs against the model.
    always @(negedge clk) begin
        for (int p = 0; p < NR; p++) begin
            check($sformatf("rd_data[%0d]", p), rd_data[p*XLEN +: XLEN], exp_data(p));
            check($sformatf("rd_busy[%0d]", p), {63'd0, rd_busy[p]}, {63'd0, exp_busy(p)});
        end
        check("busy_vec", {32'd0, busy_vec}, {32'd0, m_busy});
    end

    task automatic model_reset();
        for (int i = 0; i < RN; i++) m_rf[i] = '0;
        m_busy = '0;
    endtask

    task automatic idle();
        wr_en = '0; wr_idx = '0; wr_data = '0;
        issue_en = 1'b0; issue_idx = '0; flush = 1'b0;
    endtask

    task automatic set_wr(input int w, input logic [AW-1:0] idx, input logic [XLEN-1:0] d);
        wr_en[w] = 1'b1;
        wr_idx[w*AW +: AW] = idx;
        wr_data[w*XLEN +: XLEN] = d;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] idx);
        rd_idx[p*AW +: AW] = idx;
    endtask

    // Advance one clock edge and apply the architectural effect to the model.
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            for (int w = 0; w < NW; w++)
                if (wr_en[w] && wr_idx[w*AW +: AW] != 0)
                    m_rf[wr_idx[w*AW +: AW]] = wr_data[w*XLEN +: XLEN];
            if (flush) m_busy = '0;
            else begin
                for (int w = 0; w < NW; w++)
                    if (wr_en[w]) m_busy[wr_idx[w*AW +: AW]] = 1'b0;
                if (issue_en && issue_idx != 0) m_busy[issue_idx] = 1'b1;
            end
            m_busy[0] = 1'b0;
        end
        #1;
    endtask

    function automatic logic [AW-1:0] rnd_idx();
        return ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
    endfunction

    initial begin
        rst = 1'b1;
        rd_idx = '0;
        idle();
        model_reset();
        #2;
        check("reset busy_vec", {32'd0, busy_vec}, 64'd0);
        check("reset rd_data0", rd_data[63:0], 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // x0 protection
        set_wr(0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        issue_en = 1'b1; issue_idx = 5'd0;
        set_rd(0, 5'd0);
        @(negedge clk);
        check("x0 bypass read", rd_data[63:0], 64'd0);
        tick();
        idle();
        @(negedge clk);
        check("x0 read", rd_data[63:0], 64'd0);
        check("x0 busy", {63'd0, busy_vec[0]}, 64'd0);
        tick();

        // bypass and write-port priority
        set_wr(0, 5'd7, 64'h11);
        set_wr(1, 5'd7, 64'h22);
        set_rd(0, 5'd7);
        @(negedge clk);
        check("bypass prio", rd_data[63:0], 64'h22);
        tick();
        idle();
        set_rd(1, 5'd7);
        @(negedge clk);
        check("rf7 after write", rd_data[127:64], 64'h22);

        // scoreboard lifecycle
        issue_en = 1'b1; issue_idx = 5'd3;
        tick();
        idle();
        set_rd(0, 5'd3);
        @(negedge clk);
        check("busy3 set", {63'd0, busy_vec[3]}, 64'd1);
        check("rd_busy x3", {63'd0, rd_busy[0]}, 64'd1);
        tick();
        tick();
        tick();
        set_wr(0, 5'd3, 64'h5);
        @(negedge clk);
        check("wb x3 rd_busy", {63'd0, rd_busy[0]}, 64'd0);
        check("wb x3 data", rd_data[63:0], 64'h5);
        tick();
        idle();
        @(negedge clk);
        check("busy3 cleared", {63'd0, busy_vec[3]}, 64'd0);

        // issue/writeback collision
        issue_en = 1'b1; issue_idx = 5'd9;
        tick();
        set_wr(1, 5'd9, 64'hAB);
        tick();
        idle();
        set_rd(0, 5'd9);
        @(negedge clk);
        check("collision busy9", {63'd0, busy_vec[9]}, 64'd1);
        check("collision rf9", rd_data[63:0], 64'hAB);

        // flush priority
        issue_en = 1'b1; issue_idx = 5'd4;
        tick();
        issue_idx = 5'd6;
        tick();
        issue_idx = 5'd8;
        flush = 1'b1;
        set_wr(0, 5'd4, 64'h99);
        tick();
        idle();
        set_rd(0, 5'd4);
        @(negedge clk);
        check("flush busy_vec", {32'd0, busy_vec}, 64'd0);
        check("flush rf4", rd_data[63:0], 64'h99);

        // randomized traffic
        for (int c = 0; c < 2000; c++) begin
            tick();
            for (int w = 0; w < NW; w++) begin
                wr_en[w] = 1'($urandom_range(0, 1));
                wr_idx[w*AW +: AW] = rnd_idx();
                wr_data[w*XLEN +: XLEN] = {$urandom, $urandom};
            end
            for (int p = 0; p < NR; p++) rd_idx[p*AW +: AW] = rnd_idx();
            issue_en = 1'($urandom_range(0, 1));
            issue_idx = rnd_idx();
            flush = ($urandom_range(0, 15) == 0);
        end
        tick();
        idle();

        // asynchronous reset mid-run
        set_wr(0, 5'd5, 64'hDEAD);
        issue_en = 1'b1; issue_idx = 5'd5;
        tick();
        idle();
        set_rd(0, 5'd5);
        @(negedge clk);
        check("pre-reset x5", rd_data[63:0], 64'hDEAD);
        check("pre-reset busy5", {63'd0, busy_vec[5]}, 64'd1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("async rst x5", rd_data[63:0], 64'd0);
        check("async rst busy_vec", {32'd0, busy_vec}, 64'd0);
        #1;
        rst = 1'b0;
        tick();
        tick();
        check("post-reset x5", rd_data[63:0], 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_rv64_regfile_sb
